// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a block RAM with a byte-lane write port A and a one-cycle synchronous read port B.
// Optional macro BRAM_CTRL_FWD_EN: forward write data into a same-word read instead of stalling one cycle.
`timescale 1ns/1ps
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [31:0]           BRAM_DINA,
    output logic [3:0]            BRAM_WEA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_DOUTB,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  size_err;
    logic                  hazard;
    logic [3:0]            mask;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  wr_pend;
    logic [3:0]            wr_mask;
    logic [ADDR_WIDTH-1:0] dp_idx;
    logic                  ready_next;
    logic                  resp_next;
    logic                  unused_bits;

    // Handshake: an address phase advances on an edge where HSEL & HTRANS[1] & HREADY;
    // its data phase then lasts until the first edge with HREADY high (HREADYOUT when selected).
    assign accept      = HSEL & HTRANS[1] & HREADY;
    assign idx         = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    always_comb begin
        mask     = 4'b0000;
        size_err = 1'b0;
        case (HSIZE)
            3'd0: mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                mask     = HADDR[1] ? 4'b1100 : 4'b0011;
                size_err = HADDR[0];
            end
            3'd2: begin
                mask     = 4'b1111;
                size_err = (HADDR[1:0] != 2'b00);
            end
            default: size_err = 1'b1;
        endcase
    end

    // A read address phase landing on the word whose write commits at this same edge.
    assign hazard = accept & ~HWRITE & ~size_err & wr_pend & (idx == dp_idx);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR2: begin
                state_next = IDLE;
                if (accept && size_err) state_next = ERR1;
`ifndef BRAM_CTRL_FWD_EN
                else if (hazard) state_next = WAIT;
`endif
            end
            WAIT:    state_next = IDLE;
            ERR1:    state_next = ERR2;
            default: state_next = IDLE;
        endcase
    end

    assign ready_next = (state_next != WAIT) && (state_next != ERR1);
    assign resp_next  = (state_next == ERR1) || (state_next == ERR2);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            wr_pend   <= 1'b0;
            wr_mask   <= 4'b0000;
            dp_idx    <= '0;
        end else begin
            state     <= state_next;
            HREADYOUT <= ready_next;
            HRESP     <= resp_next;
            if (HREADY) begin
                wr_pend <= accept & HWRITE & ~size_err;
                if (accept) begin
                    dp_idx  <= idx;
                    wr_mask <= (HWRITE && !size_err) ? mask : 4'b0000;
                end
            end
        end
    end

    assign BRAM_ADDRA = dp_idx;
    assign BRAM_DINA  = HWDATA;
    assign BRAM_WEA   = wr_pend ? wr_mask : 4'b0000;
    // During WAIT the stalled read is re-issued from the held index, after the write has landed.
    assign BRAM_ADDRB = (state == WAIT) ? dp_idx : idx;
    assign dbg_state  = state;

`ifdef BRAM_CTRL_FWD_EN
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_mask <= 4'b0000;
            fwd_data <= '0;
        end else if (HREADY) begin
            fwd_mask <= hazard ? wr_mask : 4'b0000;
            if (hazard) fwd_data <= HWDATA;
        end
    end

    always_comb begin
        HRDATA = BRAM_DOUTB;
        for (int b = 0; b < 4; b++) begin
            if (fwd_mask[b]) HRDATA[8*b +: 8] = fwd_data[8*b +: 8];
        end
    end
`else
    assign HRDATA = BRAM_DOUTB;
`endif

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl: pipelined AHB master, block RAM model and a transaction-level reference memory.
`timescale 1ns/1ps
module tb_ahb_bram_ctrl;
    localparam int AW = 14;
`ifdef BRAM_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [AW-1:0] BRAM_ADDRA;
    logic [31:0]   BRAM_DINA;
    logic [3:0]    BRAM_WEA;
    logic [AW-1:0] BRAM_ADDRB;
    logic [31:0]   BRAM_DOUTB;
    logic [1:0]    dbg_state;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .BRAM_ADDRA(BRAM_ADDRA), .BRAM_DINA(BRAM_DINA),
        .BRAM_WEA(BRAM_WEA), .BRAM_ADDRB(BRAM_ADDRB), .BRAM_DOUTB(BRAM_DOUTB), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / single-slave bus ----------------
    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Block RAM: read-first, one-cycle synchronous read, byte write enables.
    logic        ram_clear;
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        if (ram_clear) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else begin
            BRAM_DOUTB <= ram[BRAM_ADDRB];
            for (int b = 0; b < 4; b++)
                if (BRAM_WEA[b]) ram[BRAM_ADDRA][8*b +: 8] <= BRAM_DINA[8*b +: 8];
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        sel;
        logic        act;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        lit_en;
        logic        wea_en;
        logic [3:0]  wea_lit;
    } txn_t;

    txn_t        txn_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [int];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic bit is_err(txn_t t);
        if (t.size > 3'd2) return 1'b1;
        return (t.addr % (32'd1 << t.size)) != 0;
    endfunction

    function automatic logic [3:0] mask_of(txn_t t);
        int m;
        m = ((1 << (1 << t.size)) - 1) << (t.addr % 4);
        return m[3:0];
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % (32'd1 << AW));
    endfunction

    function automatic logic [31:0] ref_read(int i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    task automatic ref_write(txn_t t);
        logic [31:0] w;
        logic [3:0]  m;
        w = ref_read(idx_of(t.addr));
        m = mask_of(t);
        for (int b = 0; b < 4; b++)
            if (m[b]) w[8*b +: 8] = t.wdata[8*b +: 8];
        ref_mem[idx_of(t.addr)] = w;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_ap(txn_t t);
        HSEL   = t.sel;
        HTRANS = t.act ? 2'b10 : 2'b00;
        HWRITE = t.wr;
        HADDR  = t.addr;
        HSIZE  = t.size;
    endtask

    task automatic q_wr(logic [31:0] a, logic [2:0] s, logic [31:0] d, logic we_en, logic [3:0] we);
        txn_t t;
        t = '0; t.sel = 1; t.act = 1; t.wr = 1; t.addr = a; t.size = s; t.wdata = d;
        t.wea_en = we_en; t.wea_lit = we;
        txn_q.push_back(t);
    endtask

    task automatic q_rd(logic [31:0] a, logic [2:0] s, logic lit_en, logic [31:0] lit);
        txn_t t;
        t = '0; t.sel = 1; t.act = 1; t.addr = a; t.size = s; t.lit_en = lit_en;
        txn_q.push_back(t);
        if (lit_en) exp_q.push_back(lit);
    endtask

    task automatic q_idle();
        txn_t t;
        t = '0;
        txn_q.push_back(t);
    endtask

    task automatic gen_random(int n);
        txn_t t;
        int   k;
        int   off;
        for (int i = 0; i < n; i++) begin
            t = '0;
            k = $urandom_range(0, 99);
            t.sel = (k >= 8 && k < 12) ? 1'b0 : 1'b1;
            t.act = (k < 8) ? 1'b0 : 1'b1;
            t.wr = 1'($urandom_range(0, 1));
            t.size = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 9) != 0 && t.size <= 3'd2) off = off & ~((1 << t.size) - 1);
            t.addr = 32'($urandom_range(0, 7)) * 4 + 32'(off);
            t.wdata = $urandom();
            txn_q.push_back(t);
        end
    endtask

    // Pipelined master plus per-cycle compare against the model; returns when the queue drains.
    task automatic run_queue();
        txn_t        ap;
        txn_t        dp;
        txn_t        idle_t;
        bit          dp_valid;
        bit          dp_hz;
        bit          dp_done;
        bit          err;
        bit          acc;
        bit          rdy;
        int          dp_cyc;
        int          exp_wait;
        int          guard;
        int          limit;
        logic [3:0]  exp_wea;
        logic [31:0] lit;
        idle_t   = '0;
        dp       = '0;
        dp_valid = 0;
        dp_hz    = 0;
        dp_done  = 0;
        dp_cyc   = 0;
        guard    = 0;
        limit    = 4 * txn_q.size() + 20;
        ap = idle_t;
        if (txn_q.size() != 0) ap = txn_q.pop_front();
        drive_ap(ap);
        HWDATA = $urandom();
        forever begin
            @(negedge HCLK);
            if (dp_valid) begin
                err      = is_err(dp);
                exp_wait = (err || dp_hz) ? 1 : 0;
                chk("hreadyout", {31'd0, HREADYOUT}, {31'd0, dp_cyc >= exp_wait});
                chk("hresp", {31'd0, HRESP}, {31'd0, err});
                exp_wea = (dp.wr && !err) ? mask_of(dp) : 4'b0000;
                chk("bram_wea", {28'd0, BRAM_WEA}, {28'd0, exp_wea});
                if (dp.wea_en && dp_cyc == 0) chk("bram_wea_literal", {28'd0, BRAM_WEA}, {28'd0, dp.wea_lit});
                if (exp_wea != 4'b0000) begin
                    chk("bram_addra", {18'd0, BRAM_ADDRA}, 32'(idx_of(dp.addr)));
                    chk("bram_dina", BRAM_DINA, dp.wdata);
                end
                if (!dp_done && (HREADYOUT || dp_cyc >= exp_wait)) begin
                    dp_done = 1;
                    if (dp.wr && !err) ref_write(dp);
                    else if (!dp.wr && !err) begin
                        chk("hrdata", HRDATA, ref_read(idx_of(dp.addr)));
                        if (dp.lit_en && exp_q.size() != 0) begin
                            lit = exp_q.pop_front();
                            chk("hrdata_literal", HRDATA, lit);
                        end
                    end
                end
            end else begin
                chk("idle_hreadyout", {31'd0, HREADYOUT}, 32'd1);
                chk("idle_hresp", {31'd0, HRESP}, 32'd0);
                chk("idle_wea", {28'd0, BRAM_WEA}, 32'd0);
            end
            rdy = HREADYOUT;
            @(posedge HCLK);
            #1;
            guard++;
            if (rdy) begin
                acc   = ap.sel && ap.act;
                dp_hz = acc && !FWD && !ap.wr && !is_err(ap) && dp_valid && dp.wr && !is_err(dp)
                        && idx_of(ap.addr) == idx_of(dp.addr);
                dp_valid = acc;
                dp       = ap;
                dp_cyc   = 0;
                dp_done  = 0;
                ap = idle_t;
                if (txn_q.size() != 0) ap = txn_q.pop_front();
                drive_ap(ap);
            end else begin
                dp_cyc++;
            end
            HWDATA = (dp_valid && dp.wr) ? dp.wdata : $urandom();
            if (!dp_valid && !(ap.sel && ap.act) && txn_q.size() == 0) break;
            if (guard > limit) begin
                n_chk++;
                n_fail++;
                $display("FAIL cycle_budget: ran %0d cycles, allowed %0d", guard, limit);
                break;
            end
        end
    endtask

    task automatic release_reset();
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        HRESETn   = 1'b0;
        ram_clear = 1'b1;
        drive_ap('0);
        HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("reset_hresp", {31'd0, HRESP}, 32'd0);
        chk("reset_wea", {28'd0, BRAM_WEA}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        ram_clear = 1'b0;
        release_reset();

        q_wr(32'h10, 3'd2, 32'hDEADBEEF, 1, 4'b1111);
        q_idle();
        q_rd(32'h10, 3'd2, 1, 32'hDEADBEEF);
        q_wr(32'h13, 3'd0, 32'hAA000000, 1, 4'b1000);
        q_wr(32'h10, 3'd1, 32'h00001234, 1, 4'b0011);
        q_idle();
        q_rd(32'h10, 3'd2, 1, 32'hAAAD1234);
        q_wr(32'h20, 3'd2, 32'h11223344, 1, 4'b1111);
        q_rd(32'h20, 3'd2, 1, 32'h11223344);
        q_wr(32'h20, 3'd2, 32'hCAFE0000, 0, 4'b0000);
        q_idle();
        q_wr(32'h22, 3'd1, 32'hBEEF0000, 1, 4'b1100);
        q_rd(32'h20, 3'd2, 1, 32'hBEEF0000);
        q_wr(32'h30, 3'd2, 32'h0BADF00D, 0, 4'b0000);
        q_idle();
        q_wr(32'h31, 3'd2, 32'hFFFFFFFF, 1, 4'b0000);
        q_rd(32'h30, 3'd3, 0, 32'h0);
        q_rd(32'h30, 3'd2, 1, 32'h0BADF00D);
        q_wr(32'h40, 3'd2, 32'h01020304, 0, 4'b0000);
        run_queue();

        gen_random(300);
        run_queue();

        // Reset in the middle of a write data phase.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h40; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HWDATA = 32'h55555555;
        chk("midrst_wea_before", {28'd0, BRAM_WEA}, 32'hF);
        #2 HRESETn = 1'b0;
        #1;
        chk("midrst_wea", {28'd0, BRAM_WEA}, 32'd0);
        chk("midrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        release_reset();

        // Reset in the middle of an ERROR response.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h41; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        chk("err1_hreadyout", {31'd0, HREADYOUT}, 32'd0);
        chk("err1_hresp", {31'd0, HRESP}, 32'd1);
        #2 HRESETn = 1'b0;
        #1;
        chk("errrst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("errrst_hresp", {31'd0, HRESP}, 32'd0);
        chk("errrst_state", {30'd0, dbg_state}, 32'd0);
        release_reset();

        q_rd(32'h40, 3'd2, 1, 32'h01020304);
        q_rd(32'h30, 3'd2, 1, 32'h0BADF00D);
        run_queue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
